inst_encoder: RTL
=================

# inst_encoder

Streaming RV32I instruction encoder: accepts decoded instruction fields plus a 32-bit immediate and packs them into a 32-bit instruction word. It is the inverse of the core's immediate extraction. It feeds the instruction-memory loader and the self-test program generator. A 2-entry output FIFO with valid/ready handshakes on both sides decouples producer and consumer, and each emitted word carries a sequential word address.

## Interface
- ADDR_W, 10, width of the emitted word-address counter
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of FIFO, address counter, error state
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_fmt  in  3  0=R, 1=I, 2=ISH (shift-immediate), 3=S, 4=B, 5=U, 6=J, 7=reserved
- in_opcode  in  7  opcode, placed in inst[6:0]
- in_funct3  in  3  placed in inst[14:12] for R/I/ISH/S/B
- in_funct7  in  7  placed in inst[31:25] for R/ISH
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  signed byte-offset or value immediate
- out_valid  out  1  out_inst/out_addr valid
- out_ready  in  1  consumer takes word
- out_inst  out  32  encoded instruction
- out_addr  out  ADDR_W  word address of out_inst
- range_err  out  1  sticky: an accepted immediate did not fit its format
- err_cnt  out  8  count of range violations, saturates at 255

## Operation
- Bit packing (unused fields zero):
  - R: funct7|rs2|rs1|f3|rd|op
  - I: imm[11:0]|rs1|f3|rd|op
  - ISH: funct7|imm[4:0]|rs1|f3|rd|op
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op
  - U: imm[31:12]|rd|op
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
  - reserved: emits NOP 0x00000013
- Packing is combinational on the inputs. The result is written into the FIFO on accept (in_valid && in_ready).
- Legal immediate ranges:
  - I/S: -2048..2047
  - ISH: imm[31:5]==0
  - B: even, -4096..4094
  - U: imm[11:0]==0
  - J: even, -1048576..1048574
  - R/reserved: immediate ignored
- An out-of-range immediate is still encoded, with the out-of-range bits truncated. It sets range_err and increments err_cnt.
- FIFO: 2 entries, in order. in_ready = !full. A push and a pop in the same cycle are both honoured.
- out_addr counter: increments on each pop (out_valid && out_ready) and wraps from 2^ADDR_W-1 to 0. The head word shows the current counter value.
- flush: takes precedence over push and pop. It empties the FIFO and zeroes the counter, range_err and err_cnt. Any bundle presented in the flush cycle is dropped.

## Timing
- Reset and flush values: out_valid=0, out_inst=0, out_addr=0, range_err=0, err_cnt=0, in_ready=1.
- Latency: a bundle accepted at edge N gives out_valid=1 in the cycle after edge N. There is no combinational in→out path.
- in_ready depends only on FIFO occupancy, not on out_ready. When the FIFO is full, a pop in the same cycle does not allow a push.
- out_inst and out_valid stay stable while out_valid && !out_ready.
- reset_n assertion mid-stream clears all state immediately (asynchronous). Deassertion is synchronised externally.
- range_err and err_cnt update at the accept edge.

## Configuration
- INST_ENCODER_RANGE_CHECK_EN defined: range checking as described.
- Not defined: no checking logic. range_err=0 and err_cnt=0 constant. Encoding and truncation are unchanged.

## Test plan
- ADDI x1,x0,-1 (fmt 1, op 0x13, f3 0, rd 1, imm 0xFFFFFFFF) → out_inst 0xFFF00093, out_addr 0, one cycle after accept.
- BEQ x1,x2,-4 (fmt 4, op 0x63, rs1 1, rs2 2, imm 0xFFFFFFFC) → 0xFE208EE3.
- JAL x1,+2048 (fmt 6, op 0x6F, rd 1, imm 0x800) → 0x001000EF.
- ADDI x1,x0,2048 with the macro defined → 0x80000093, range_err=1, err_cnt=1. Without the macro → same word, range_err=0.
- Backpressure: out_ready=0, push 3 bundles → in_ready drops after 2. With out_ready=1 all three words emerge in order with out_addr 0,1,2. The counter wraps to 0 after 2^ADDR_W pops.
- flush or reset_n low with 2 words queued and err_cnt>0 → next cycle out_valid=0, out_addr=0, err_cnt=0, in_ready=1.

Source files
------------

// File: rtl/inst_encoder.sv
// Streaming RV32I instruction encoder: packs decoded fields and an immediate into a
// 32-bit word behind a 2-entry FIFO. Define INST_ENCODER_RANGE_CHECK_EN for immediate range checking.
module inst_encoder #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_fmt,
   input  logic [6:0]        in_opcode,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [31:0]       in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_inst,
   output logic [ADDR_W-1:0] out_addr,
   output logic              range_err,
   output logic [7:0]        err_cnt
);

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_ISH = 3'd2,
      FMT_S   = 3'd3,
      FMT_B   = 3'd4,
      FMT_U   = 3'd5,
      FMT_J   = 3'd6,
      FMT_RSV = 3'd7
   } fmt_e;

   fmt_e        fmt;
   logic [31:0] packed_inst;
   logic [31:0] mem [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  count;
   logic        push;
   logic        pop;

   assign fmt = fmt_e'(in_fmt);

   always_comb begin
      packed_inst = 32'h0000_0013;
      case (fmt)
         FMT_R:   packed_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
         FMT_I:   packed_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
         FMT_ISH: packed_inst = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
         FMT_S:   packed_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
         FMT_B:   packed_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                 in_imm[4:1], in_imm[11], in_opcode};
         FMT_U:   packed_inst = {in_imm[31:12], in_rd, in_opcode};
         FMT_J:   packed_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                 in_rd, in_opcode};
         default: packed_inst = 32'h0000_0013;
      endcase
   end

   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;
   assign out_inst  = out_valid ? mem[rd_ptr] : 32'h0;

   // Storage needs no reset: out_inst is masked whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= packed_inst;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         count    <= 2'd0;
         out_addr <= '0;
      end else if (flush) begin
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         count    <= 2'd0;
         out_addr <= '0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop) begin
            rd_ptr   <= ~rd_ptr;
            out_addr <= out_addr + 1'b1;
         end
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

`ifdef INST_ENCODER_RANGE_CHECK_EN
   logic imm_bad;

   always_comb begin
      imm_bad = 1'b0;
      case (fmt)
         FMT_I, FMT_S: imm_bad = (in_imm[31:11] != {21{in_imm[11]}});
         FMT_ISH:      imm_bad = |in_imm[31:5];
         FMT_B:        imm_bad = in_imm[0] || (in_imm[31:12] != {20{in_imm[12]}});
         FMT_U:        imm_bad = |in_imm[11:0];
         FMT_J:        imm_bad = in_imm[0] || (in_imm[31:20] != {12{in_imm[20]}});
         default:      imm_bad = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         range_err <= 1'b0;
         err_cnt   <= 8'd0;
      end else if (flush) begin
         range_err <= 1'b0;
         err_cnt   <= 8'd0;
      end else if (push && imm_bad) begin
         range_err <= 1'b1;
         if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
   end
`else
   assign range_err = 1'b0;
   assign err_cnt   = 8'd0;
`endif

endmodule
